// File: rtl/risc_phase_controller_if.sv
// Opcode/flag inputs and memory/datapath strobes between the phase controller and the core.
interface risc_phase_controller_if #(
  parameter int OPW = 3
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic [2:0]     phase;
  logic           sel;
  logic           mem_rd;
  logic           mem_wr;
  logic           ld_ir;
  logic           ld_ac;
  logic           ld_pc;
  logic           inc_pc;
  logic           data_e;
  logic           halt;

  modport master (
    input  opcode, zero,
    output phase, sel, mem_rd, mem_wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt
  );

  modport slave (
    output opcode, zero,
    input  phase, sel, mem_rd, mem_wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt
  );
endinterface

// File: rtl/risc_phase_controller.sv
// 8-phase VeriRISC sequencer; strobes are a zero-latency decode of the phase register.
// No backpressure: free-running, one instruction per 8 clocks; a sticky HLT freezes it.
module risc_phase_controller #(
  parameter int OPW         = 3,
  parameter bit HALT_STICKY = 1'b1
) (
  input logic                     clk,
  input logic                     rst_n,
  risc_phase_controller_if.master bus
);

  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;

  logic sel, mem_rd, mem_wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic is_alu, is_hlt, is_skz, is_sto, is_jmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    is_alu = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
             (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
    is_hlt = (bus.opcode == OP_HLT);
    is_skz = (bus.opcode == OP_SKZ);
    is_sto = (bus.opcode == OP_STO);
    is_jmp = (bus.opcode == OP_JMP);

    phase_d  = phase_t'(phase_q + 3'd1);
    halted_d = halted_q;
    sel      = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ld_ir    = 1'b0;
    ld_ac    = 1'b0;
    ld_pc    = 1'b0;
    inc_pc   = 1'b0;
    data_e   = 1'b0;
    halt     = 1'b0;

    if (halted_q) begin
      // Frozen in OP_ADDR; suppress the phase-4 inc_pc so PC stays put.
      phase_d = phase_q;
      halt    = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel    = 1'b1;
          mem_rd = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel    = 1'b1;
          mem_rd = 1'b1;
          ld_ir  = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
          if (HALT_STICKY && is_hlt) begin
            halted_d = 1'b1;
            phase_d  = phase_q;
          end
        end
        OP_FETCH: begin
          mem_rd = is_alu;
        end
        ALU_OP: begin
          mem_rd = is_alu;
          inc_pc = is_skz && bus.zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          mem_rd = is_alu;
          ld_ac  = is_alu;
          ld_pc  = is_jmp;
          mem_wr = is_sto;
          data_e = is_sto;
        end
        default: begin
          sel = 1'b1;
        end
      endcase
    end
  end

  assign bus.phase  = phase_q;
  assign bus.sel    = sel;
  assign bus.mem_rd = mem_rd;
  assign bus.mem_wr = mem_wr;
  assign bus.ld_ir  = ld_ir;
  assign bus.ld_ac  = ld_ac;
  assign bus.ld_pc  = ld_pc;
  assign bus.inc_pc = inc_pc;
  assign bus.data_e = data_e;
  assign bus.halt   = halt;

endmodule

// File: tb/tb_risc_phase_controller.sv
// Scoreboard bench: a sticky-halt and a pulse-halt controller checked against hand-built phase tables.
module tb_risc_phase_controller;

  localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7;

  // Output vector bit order: {sel, mem_rd, mem_wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
  localparam logic [35:0] T_FETCH = {9'h100, 9'h180, 9'h1A0, 9'h1A0};
  localparam logic [35:0] T_ALU   = {9'h004, 9'h080, 9'h080, 9'h090};
  localparam logic [35:0] T_STO   = {9'h004, 9'h000, 9'h002, 9'h042};
  localparam logic [35:0] T_SKZ1  = {9'h004, 9'h000, 9'h004, 9'h000};
  localparam logic [35:0] T_SKZ0  = {9'h004, 9'h000, 9'h000, 9'h000};
  localparam logic [35:0] T_JMP   = {9'h004, 9'h000, 9'h008, 9'h008};
  localparam logic [35:0] T_HLTP  = {9'h005, 9'h000, 9'h000, 9'h000};
  localparam logic [8:0]  V_RST   = 9'h100;
  localparam logic [8:0]  V_HALT  = 9'h001;

  logic clk;
  logic rst_s, rst_p;
  bit   fresh;

  risc_phase_controller_if #(.OPW(3)) bus_s ();
  risc_phase_controller_if #(.OPW(3)) bus_p ();

  risc_phase_controller #(.OPW(3), .HALT_STICKY(1'b1)) dut_s (
    .clk   (clk),
    .rst_n (rst_s),
    .bus   (bus_s)
  );

  risc_phase_controller #(.OPW(3), .HALT_STICKY(1'b0)) dut_p (
    .clk   (clk),
    .rst_n (rst_p),
    .bus   (bus_p)
  );

  typedef struct {
    bit         d;
    logic [2:0] ph;
    logic [8:0] v;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] observe(input bit d);
    if (d)
      return {bus_p.phase, bus_p.sel, bus_p.mem_rd, bus_p.mem_wr, bus_p.ld_ir, bus_p.ld_ac,
              bus_p.ld_pc, bus_p.inc_pc, bus_p.data_e, bus_p.halt};
    return {bus_s.phase, bus_s.sel, bus_s.mem_rd, bus_s.mem_wr, bus_s.ld_ir, bus_s.ld_ac,
            bus_s.ld_pc, bus_s.inc_pc, bus_s.data_e, bus_s.halt};
  endfunction

  // Monitor: bus-contention rules every cycle, then every queued expectation for this cycle.
  always @(negedge clk) begin
    logic [11:0] o;
    exp_t        e;
    for (int d = 0; d < 2; d++) begin
      o = observe(d[0]);
      n_vec++;
      if ((o[7] && o[1]) || (o[6] && !o[1])) begin
        n_bad++;
        $display("FAIL contention dut=%0d got rd=%b wr=%b de=%b want rd&de=0 and wr->de",
                 d, o[7], o[6], o[1]);
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.d);
      n_vec++;
      if (o !== {e.ph, e.v}) begin
        n_bad++;
        $display("FAIL %s dut=%s got phase=%0d out=%03h want phase=%0d out=%03h",
                 e.nm, e.d ? "pulse" : "sticky", o[11:9], o[8:0], e.ph, e.v);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit [1:0] m, input logic [2:0] op, input logic z);
    if (m[0]) begin bus_s.opcode = op; bus_s.zero = z; end
    if (m[1]) begin bus_p.opcode = op; bus_p.zero = z; end
  endtask

  task automatic push(input bit [1:0] m, input logic [2:0] ph, input logic [8:0] v,
                      input string nm);
    exp_t e;
    e.ph = ph;
    e.v  = v;
    e.nm = nm;
    if (m[0]) begin e.d = 1'b0; sb.push_back(e); end
    if (m[1]) begin e.d = 1'b1; sb.push_back(e); end
  endtask

  // Phases 0-2 carry a deliberately wrong opcode/zero: the decode must ignore them there.
  task automatic run_instr(input bit [1:0] m, input logic [2:0] op, input logic z,
                           input logic [35:0] back, input int nph, input string nm);
    logic [35:0] f;
    logic [8:0]  v;
    f = T_FETCH;
    for (int ph = 0; ph < nph; ph++) begin
      if (fresh) fresh = 1'b0;
      else       step();
      if (ph < 3) drive(m, ~op, ~z);
      else        drive(m, op, z);
      v = (ph < 4) ? f[35-9*ph -: 9] : back[35-9*(ph-4) -: 9];
      push(m, 3'(ph), v, $sformatf("%s.p%0d", nm, ph));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired with %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] f;
    logic [35:0] h;
    rst_s = 1'b0;
    rst_p = 1'b0;
    fresh = 1'b0;
    drive(2'b11, OP_HLT, 1'b1);

    step();
    push(2'b11, 3'd0, V_RST, "reset");
    step();
    rst_s = 1'b1;
    rst_p = 1'b1;
    fresh = 1'b1;

    run_instr(2'b11, OP_ADD, 1'b0, T_ALU,  8, "add0");
    run_instr(2'b11, OP_ADD, 1'b0, T_ALU,  8, "add1");
    run_instr(2'b11, OP_AND, 1'b1, T_ALU,  8, "and");
    run_instr(2'b11, OP_XOR, 1'b0, T_ALU,  8, "xor");
    run_instr(2'b11, OP_LDA, 1'b1, T_ALU,  8, "lda");
    run_instr(2'b11, OP_STO, 1'b0, T_STO,  8, "sto");
    run_instr(2'b11, OP_SKZ, 1'b1, T_SKZ1, 8, "skz_z1");
    run_instr(2'b11, OP_SKZ, 1'b0, T_SKZ0, 8, "skz_z0");
    run_instr(2'b11, OP_JMP, 1'b1, T_JMP,  8, "jmp");

    // HLT: pulse DUT moves on to phase 5, sticky DUT parks in phase 4.
    f = T_FETCH;
    h = T_HLTP;
    for (int ph = 0; ph < 8; ph++) begin
      step();
      drive(2'b11, (ph < 3) ? OP_JMP : OP_HLT, 1'b0);
      push(2'b10, 3'(ph), (ph < 4) ? f[35-9*ph -: 9] : h[35-9*(ph-4) -: 9],
           $sformatf("hlt_pulse.p%0d", ph));
      if (ph <= 4)
        push(2'b01, 3'(ph), (ph < 4) ? f[35-9*ph -: 9] : h[35-9*(ph-4) -: 9],
             $sformatf("hlt_sticky.p%0d", ph));
      else
        push(2'b01, 3'd4, V_HALT, $sformatf("hlt_sticky.p%0d", ph));
    end
    for (int k = 0; k < 20; k++) begin
      step();
      drive(2'b01, 3'(k), k[0]);
      push(2'b01, 3'd4, V_HALT, $sformatf("halted.%0d", k));
    end
    step();
    rst_s = 1'b0;
    rst_p = 1'b0;
    push(2'b11, 3'd0, V_RST, "halt_rst");
    step();
    rst_s = 1'b1;
    rst_p = 1'b1;
    fresh = 1'b1;
    run_instr(2'b11, OP_ADD, 1'b0, T_ALU, 8, "post_halt");

    // Reset asserted between edges during phase 7 of STO.
    run_instr(2'b11, OP_STO, 1'b0, T_STO, 8, "sto_a");
    run_instr(2'b11, OP_STO, 1'b0, T_STO, 7, "sto_b");
    step();
    drive(2'b11, OP_STO, 1'b0);
    #2;
    rst_s = 1'b0;
    rst_p = 1'b0;
    push(2'b11, 3'd0, V_RST, "sto_mid_rst");
    step();
    rst_s = 1'b1;
    rst_p = 1'b1;
    fresh = 1'b1;
    run_instr(2'b11, OP_LDA, 1'b0, T_ALU, 8, "post_rst");

    step();
    step();
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
